// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbitration controller: opcodes, legal range,
// FSM encoding and flag bit positions.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_OR  = 4'b0101;
   localparam logic [3:0] OP_XOR = 4'b0110;
   localparam logic [3:0] OP_NOT = 4'b0111;

   localparam logic [3:0] OP_MIN = OP_ADD;
   localparam logic [3:0] OP_MAX = OP_NOT;

   localparam int FLAG_CF = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_SF = 1;
   localparam int FLAG_ZF = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } state_e;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op >= OP_MIN) && (op <= OP_MAX);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves past the winner only when
// the caller signals that the grant was actually taken.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt,
   output logic       gnt_id
);

   logic ptr_q;
   logic ptr_d;

   // Priority starts at the pointer; fall back to the other requester.
   always_comb begin
      gnt_id = ptr_q;
      gnt    = 2'b00;
      if (req[ptr_q]) begin
         gnt_id = ptr_q;
      end else if (req[~ptr_q]) begin
         gnt_id = ~ptr_q;
      end else begin
         gnt_id = ptr_q;
      end
      if (req != 2'b00) begin
         gnt = 2'b01 << gnt_id;
      end else begin
         gnt = 2'b00;
      end
      if (update) begin
         ptr_d = ~gnt_id;
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Shares one registered ALU between two valid/ready requesters, one
// transaction at a time, capturing result and flags into local registers.
module alu_arbiter_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [3:0]       req0_op,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [1:0]       resp_valid,
   input  logic [1:0]       resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic [3:0]       resp_flags,
   output logic             resp_err,
   output logic [3:0]       alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_en,
   output logic             alu_oe,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_cf,
   input  logic             alu_of,
   input  logic             alu_sf,
   input  logic             alu_zf,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   state_e           state_q, state_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       flags_q, flags_d;
   logic [1:0]       resp_valid_q, resp_valid_d;
   logic [3:0]       alu_opcode_q, alu_opcode_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             alu_en_q, alu_en_d;
   logic             alu_oe_q, alu_oe_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic [1:0]       arb_req_s;
   logic [1:0]       arb_gnt_s;
   logic             gnt_id_s;
   logic             req_hs_s;
   logic [3:0]       sel_op_s;
   logic [WIDTH-1:0] sel_a_s;
   logic [WIDTH-1:0] sel_b_s;

   // Requests are only offered to the arbiter while idle and out of reset.
   assign arb_req_s = ((state_q == ST_IDLE) && !rst) ? req_valid : 2'b00;
   assign req_hs_s  = |(req_valid & arb_gnt_s);
   assign sel_op_s  = gnt_id_s ? req1_op : req0_op;
   assign sel_a_s   = gnt_id_s ? req1_a  : req0_a;
   assign sel_b_s   = gnt_id_s ? req1_b  : req0_b;

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (arb_req_s),
      .update (req_hs_s),
      .gnt    (arb_gnt_s),
      .gnt_id (gnt_id_s)
   );

   // Next-state and next-output logic for the transaction sequencer.
   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      err_d        = err_q;
      data_d       = data_q;
      flags_d      = flags_q;
      resp_valid_d = resp_valid_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_en_d     = 1'b0;
      alu_oe_d     = 1'b0;
      op_count_d   = op_count_q;
      case (state_q)
         ST_IDLE: begin
            if (req_hs_s) begin
               id_d = gnt_id_s;
               if (op_is_legal(sel_op_s)) begin
                  alu_opcode_d = sel_op_s;
                  alu_a_d      = sel_a_s;
                  alu_b_d      = sel_b_s;
                  alu_en_d     = 1'b1;
                  state_d      = ST_ISSUE;
               end else begin
                  // Rejected opcodes never reach the ALU pins.
                  err_d        = 1'b1;
                  data_d       = {WIDTH{1'b0}};
                  flags_d      = 4'b0000;
                  resp_valid_d = 2'b01 << gnt_id_s;
                  state_d      = ST_RESP;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            alu_oe_d = 1'b1;
            state_d  = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            data_d           = alu_out;
            flags_d[FLAG_CF] = alu_cf;
            flags_d[FLAG_OF] = alu_of;
            flags_d[FLAG_SF] = alu_sf;
            flags_d[FLAG_ZF] = alu_zf;
            err_d            = 1'b0;
            resp_valid_d     = 2'b01 << id_q;
            state_d          = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready[id_q]) begin
               resp_valid_d = 2'b00;
               state_d      = ST_IDLE;
               if (!err_q && (op_count_q != {CNT_W{1'b1}})) begin
                  op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  op_count_d = op_count_q;
               end
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            resp_valid_d = 2'b00;
            state_d      = ST_IDLE;
         end
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         id_q         <= 1'b0;
         err_q        <= 1'b0;
         data_q       <= {WIDTH{1'b0}};
         flags_q      <= 4'b0000;
         resp_valid_q <= 2'b00;
         alu_opcode_q <= 4'b0000;
         alu_a_q      <= {WIDTH{1'b0}};
         alu_b_q      <= {WIDTH{1'b0}};
         alu_en_q     <= 1'b0;
         alu_oe_q     <= 1'b0;
         op_count_q   <= {CNT_W{1'b0}};
      end else begin
         state_q      <= state_d;
         id_q         <= id_d;
         err_q        <= err_d;
         data_q       <= data_d;
         flags_q      <= flags_d;
         resp_valid_q <= resp_valid_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_en_q     <= alu_en_d;
         alu_oe_q     <= alu_oe_d;
         op_count_q   <= op_count_d;
      end
   end

   assign req_ready  = arb_gnt_s;
   assign resp_valid = resp_valid_q;
   assign resp_data  = data_q;
   assign resp_flags = flags_q;
   assign resp_err   = err_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_en     = alu_en_q;
   assign alu_oe     = alu_oe_q;
   assign busy       = (state_q != ST_IDLE);
   assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Scoreboard bench for alu_arbiter_ctrl with a behavioural ALU, a round-robin
// reference and randomized traffic from both requesters.
module tb_alu_arbiter_ctrl;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [3:0] req0_op = 4'h0, req1_op = 4'h0;
   logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
   logic [1:0] resp_valid;
   logic [1:0] resp_ready = 2'b00;
   logic [7:0] resp_data;
   logic [3:0] resp_flags;
   logic       resp_err;
   logic [3:0] alu_opcode;
   logic [7:0] alu_a, alu_b;
   logic       alu_en, alu_oe;
   wire  [7:0] alu_out;
   logic       alu_cf, alu_of, alu_sf, alu_zf;
   logic       busy;
   logic [15:0] op_count;

   always #5 clk = ~clk;

   alu_arbiter_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_a(req1_a), .req1_b(req1_b), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .resp_flags(resp_flags),
      .resp_err(resp_err), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_en(alu_en), .alu_oe(alu_oe), .alu_out(alu_out), .alu_cf(alu_cf),
      .alu_of(alu_of), .alu_sf(alu_sf), .alu_zf(alu_zf), .busy(busy),
      .op_count(op_count)
   );

   // Reference arithmetic: returns {CF,OF,SF,ZF,result} from integer math.
   function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int ua, ub, sa, sb, ures, sres;
      logic [7:0] r;
      logic cf, ovf;
      ua = int'(a); ub = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      cf = 1'b0; ovf = 1'b0; r = 8'h00;
      case (op)
         OP_ADD: begin ures = ua + ub; sres = sa + sb; r = ures[7:0];
                       cf = (ures > 255); ovf = (sres > 127) || (sres < -128); end
         OP_SUB: begin ures = ua - ub; sres = sa - sb; r = ures[7:0];
                       cf = (ua < ub); ovf = (sres > 127) || (sres < -128); end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_NOT: r = ~a;
         default: r = 8'h00;
      endcase
      return {cf, ovf, r[7], (r == 8'h00), r};
   endfunction

   // Behavioural registered ALU with tri-stated result; flags never reset.
   logic [7:0] alu_res_r = 8'h5A;
   logic [3:0] alu_flg_r = 4'b1111;
   always @(posedge clk) if (alu_en) {alu_flg_r, alu_res_r} <= ref_alu(alu_opcode, alu_a, alu_b);
   assign alu_out = alu_oe ? alu_res_r : 8'hzz;
   assign {alu_cf, alu_of, alu_sf, alu_zf} = alu_flg_r;

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   typedef struct { logic id; logic [7:0] data; logic [3:0] flags; logic err; } exp_t;
   exp_t exp_q[$];
   int   grant_log[$];
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor state: reference pointer, counter, and response history.
   logic        m_ptr = 1'b0;
   logic [15:0] m_cnt = 16'h0;
   logic        en_exp = 1'b0;
   int          hs_cyc = 0;
   logic [1:0]  prev_rv = 2'b00;
   logic [12:0] prev_resp = 13'h0;
   logic [1:0]  g_exp;
   exp_t        e;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete(); m_ptr = 1'b0; m_cnt = 16'h0; en_exp = 1'b0; prev_rv = 2'b00;
      end else begin
         chk("alu_en", alu_en, en_exp);
         en_exp = 1'b0;
         if (req_valid == 2'b00) g_exp = 2'b00;
         else if (req_valid[m_ptr]) g_exp = 2'b01 << m_ptr;
         else g_exp = 2'b01 << ~m_ptr;
         chk("req_ready", req_ready, busy ? 2'b00 : g_exp);
         if ((req_valid & req_ready) != 2'b00) begin
            e.id = req_ready[1];
            if (e.id) {e.flags, e.data} = ref_alu(req1_op, req1_a, req1_b);
            else      {e.flags, e.data} = ref_alu(req0_op, req0_a, req0_b);
            e.err = !(((e.id ? req1_op : req0_op) >= 4'd2) && ((e.id ? req1_op : req0_op) <= 4'd7));
            if (e.err) begin e.data = 8'h00; e.flags = 4'h0; end
            en_exp = !e.err;
            exp_q.push_back(e);
            grant_log.push_back(int'(e.id));
            hs_cyc = cyc;
            m_ptr = ~e.id;
         end
         if (resp_valid != 2'b00) begin
            chk("resp_onehot", $countones(resp_valid), 1);
            chk("busy_in_resp", busy, 1'b1);
            chk("resp_expected", exp_q.size() > 0, 1'b1);
            if (prev_rv == 2'b00) begin
               if (exp_q.size() > 0) chk("latency", cyc - hs_cyc, exp_q[0].err ? 1 : 3);
            end else begin
               chk("resp_hold", {resp_err, resp_flags, resp_data}, prev_resp);
               chk("resp_valid_hold", resp_valid, prev_rv);
            end
            if (((resp_valid & resp_ready) != 2'b00) && (exp_q.size() > 0)) begin
               e = exp_q.pop_front();
               chk("resp_id", resp_valid, 2'b01 << e.id);
               chk("resp_data", resp_data, e.data);
               chk("resp_flags", resp_flags, e.flags);
               chk("resp_err", resp_err, e.err);
               chk("op_count", op_count, m_cnt);
               if (!e.err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
         end
         prev_rv = resp_valid;
         prev_resp = {resp_err, resp_flags, resp_data};
      end
   end

   // Response-ready policy: 0 always ready, 1 random, 3 left to the main flow.
   int rmode = 0;
   always @(posedge clk) begin
      #1;
      if (rmode == 0) resp_ready = 2'b11;
      else if (rmode == 1) resp_ready = 2'($urandom);
      else resp_ready = resp_ready;
   end

   task automatic do_req(input int id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int t;
      @(posedge clk); #1;
      if (id == 0) begin req0_op = op; req0_a = a; req0_b = b; end
      else begin req1_op = op; req1_a = a; req1_b = b; end
      req_valid[id] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!(req_valid[id] && req_ready[id]) && t < 300);
      chk("req_accepted", t < 300, 1'b1);
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_resp(input int id);
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!resp_valid[id] && t < 300);
      chk("resp_arrived", resp_valid[id], 1'b1);
   endtask

   task automatic drain();
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while ((busy || exp_q.size() != 0 || req_valid != 2'b00) && t < 2000);
      chk("drained", t < 2000, 1'b1);
   endtask

   task automatic rand_traffic(input int id, input int n);
      for (int k = 0; k < n; k++) begin
         do_req(id, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   logic [15:0] cnt_before;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_outputs", {req_ready, resp_valid, resp_data, resp_flags, resp_err, alu_en, alu_oe, busy}, 20'h0);
      chk("rst_alu_drive", {alu_opcode, alu_a, alu_b}, 20'h0);
      chk("rst_op_count", op_count, 16'h0);

      do_req(0, OP_ADD, 8'h7F, 8'h01);
      wait_resp(0);
      chk("add_data", resp_data, 8'h80);
      chk("add_flags", resp_flags, 4'b0110);
      drain();
      chk("add_count", op_count, 16'd1);

      do_req(1, OP_SUB, 8'h05, 8'h07);
      wait_resp(1);
      chk("sub_data", resp_data, 8'hFE);
      chk("sub_flags", resp_flags, 4'b1010);
      drain();

      cnt_before = op_count;
      do_req(0, 4'b1000, 8'h12, 8'h34);
      wait_resp(0);
      chk("illegal_err", resp_err, 1'b1);
      chk("illegal_data", {resp_flags, resp_data}, 12'h000);
      drain();
      chk("illegal_count", op_count, cnt_before);

      rmode = 3; resp_ready = 2'b00;
      do_req(0, OP_ADD, 8'($urandom), 8'($urandom));
      fork
         do_req(1, OP_OR, 8'($urandom), 8'($urandom));
         begin
            wait_resp(0);
            repeat (5) begin
               @(negedge clk);
               chk("bp_busy", busy, 1'b1);
               chk("bp_req_ready", req_ready, 2'b00);
            end
            @(posedge clk); #1 resp_ready = 2'b01;
            @(negedge clk);
            @(negedge clk);
            chk("bp_idle", busy, 1'b0);
            rmode = 0;
         end
      join
      drain();

      do_req(0, OP_ADD, 8'h11, 8'h22);
      chk("issue_before_rst", alu_en, 1'b1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("midrst_outputs", {req_ready, resp_valid, resp_data, resp_flags, resp_err, alu_en, alu_oe, busy}, 20'h0);
      chk("midrst_op_count", op_count, 16'h0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (4) begin @(negedge clk); chk("midrst_no_resp", resp_valid, 2'b00); end

      grant_log.delete();
      fork
         for (int k = 0; k < 4; k++) do_req(0, OP_XOR, 8'hAA, 8'hAA);
         for (int k = 0; k < 4; k++) do_req(1, OP_XOR, 8'hAA, 8'hAA);
      join
      drain();
      chk("alt_count", grant_log.size(), 8);
      for (int k = 0; k < grant_log.size() && k < 8; k++) chk("alt_grant", grant_log[k], k % 2);

      rmode = 1;
      fork
         rand_traffic(0, 20);
         rand_traffic(1, 20);
      join
      rmode = 0;
      drain();
      chk("final_count", op_count, m_cnt);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/alu_arbiter_ctrl.md
Name: alu_arbiter_ctrl

Overview:
- Shares one registered 8-bit ALU (opcode 4'b0010..4'b0111, result and CF/OF/SF/ZF updated on the clk edge while en=1, output tri-stated unless oe=1) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one transaction in flight at a time.
- Sequences the ALU's en/oe, captures the result and flags into its own registers, and rejects unsupported opcodes without touching the ALU.

Parameters:
- WIDTH, 8, operand/result width; must match the ALU WIDTH.
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  rising-edge clock, same clock as the ALU.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester request accept.
- req0_op, req1_op  input  4 each  requested opcode.
- req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
- resp_valid  output  2  per-requester response valid.
- resp_ready  input  2  per-requester response accept.
- resp_data  output  WIDTH  result, shared bus; meaningful only for the requester whose resp_valid bit is set.
- resp_flags  output  4  {CF,OF,SF,ZF} of the captured result.
- resp_err  output  1  1 = unsupported opcode, rejected.
- alu_opcode  output  4  drives ALU OPCODE.
- alu_a, alu_b  output  WIDTH each  drive ALU A and B.
- alu_en  output  1  drives ALU en.
- alu_oe  output  1  drives ALU oe.
- alu_out  input  WIDTH  from ALU_OUT.
- alu_cf, alu_of, alu_sf, alu_zf  input  1 each  ALU flags.
- busy  output  1  high in every state except IDLE.
- op_count  output  CNT_W  completed non-error transactions, saturating.

Behaviour:
- Reset:
  - State IDLE; rr pointer = requester 0.
  - All outputs 0; req_ready=0, resp_valid=0, alu_en=0, alu_oe=0, op_count=0.
  - Captured data/flags/err cleared.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Grant = highest-priority requester with req_valid set. Priority starts at the rr pointer.
  - req_ready is combinational, one-hot on the granted requester, and 0 when no request is valid.
  - On handshake (valid & ready), latch op, a, b and the requester id.
  - The rr pointer moves to the other requester only after a grant. Simultaneous requests therefore alternate 0,1,0,1.
  - If the latched op is outside 4'b0010..4'b0111: set err=1, data=0, flags=0, go to RESP. The ALU is never enabled.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - alu_opcode, alu_a, alu_b driven from the latched values; alu_en=1.
  - The ALU registers its result at the end of this cycle.
- CAPTURE (1 cycle):
  - alu_en=0, alu_oe=1.
  - alu_out and the four flags are captured at the end of the cycle; err=0.
  - Go to RESP.
- RESP:
  - resp_valid[id]=1; resp_data/flags/err held stable until resp_ready[id]=1.
  - On that handshake: go to IDLE and increment op_count if err=0 (saturating at all-ones).
  - resp_ready on the non-owning bit is ignored.
- ALU drive outside active states:
  - alu_opcode/a/b hold their last values; alu_en=0.
  - alu_oe=1 only in CAPTURE, so the ALU bus is Z in all other states.
- Latency, request handshake at edge T:
  - Legal op: resp_valid rises in cycle T+3.
  - Illegal op: resp_valid rises in cycle T+1.
  - Throughput: at best one legal op per 4 cycles. A new request is accepted the cycle after the response handshake (IDLE).
- Back-pressure: req_ready stays 0 in ISSUE, CAPTURE and RESP. Requests may stay valid while waiting; no request is dropped.
- Reset mid-operation (any state): the transaction is discarded, no response is issued, and all reset values apply the next cycle. The ALU's internal flags are not reset; the controller never forwards them uncaptured.
- Width rule: resp_data = alu_out[WIDTH-1:0]. Flags are taken only from the ALU flag pins, never recomputed.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=4'b0010, OP_SUB=4'b0011, OP_AND=4'b0100, OP_OR=4'b0101, OP_XOR=4'b0110, OP_NOT=4'b0111;
  - the legal-opcode range;
  - FSM state encoding;
  - flag bit indices CF=3, OF=2, SF=1, ZF=0.
- One sub-module rr_arbiter2: 2-way round-robin grant with a pointer-update input. The FSM, latches and counter stay in the top.

Test Plan:
- req0 ADD a=8'h7F b=8'h01 -> resp_valid[0] rises 3 cycles after the handshake; data 8'h80, flags 4'b0110 (CF=0 OF=1 SF=1 ZF=0); op_count=1.
- req1 SUB a=8'h05 b=8'h07 -> data 8'hFE, CF=1, SF=1, ZF=0. resp_valid[1] only; resp_valid[0] stays 0.
- Both requests valid every cycle from reset, XOR with a=b=8'hAA -> grants alternate 0,1,0,1; each response data 8'h00 with ZF=1; no starvation over 8 transactions.
- req0 op 4'b1000 -> resp_err=1, data 8'h00, flags 0, one cycle after the handshake; alu_en never asserted; op_count unchanged.
- ADD response with resp_ready[0]=0 for 5 cycles -> data/flags stable, busy=1, req_ready=0 throughout; IDLE the cycle after resp_ready[0]=1.
- rst asserted during ISSUE -> next cycle all outputs 0, no resp_valid pulse, rr pointer back to requester 0, alu_oe=0.
